rr_arb_mux: RTL

Parametrised N-way arbitrated multiplexer with a registered output stage. It is the sequential successor to the fixed 3-input combinational mux in the cpu datapath. N producer channels each offer WIDTH-bit data under valid/ready. One channel per cycle is granted, by round-robin or fixed priority, and its data is registered toward a single consumer. Used for shared write-back and memory-request ports in the cpu.

---
 rtl/mux_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/rr_arb_mux.sv | 58 +++++
 3 files changed

// File: rtl/mux_pkg.sv
// Helpers shared by the datapath multiplexers.
// Holds the one-hot to binary index conversion used by the arbiters and muxes.
package mux_pkg;

  localparam int unsigned MAX_N = 32;

  // Callers zero-extend their one-hot vector to MAX_N and truncate the result to their own index width.
  function automatic logic [31:0] onehot_to_idx(input logic [MAX_N-1:0] onehot);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (onehot[i]) idx = idx | 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter: round-robin from a rotating pointer, or fixed priority with the lowest index winning.
// The pointer moves past the granted channel only when the caller reports a transfer via advance.
module rr_arbiter #(
  parameter int N  = 3,
  parameter bit RR = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  import mux_pkg::*;

  localparam int SELW = $clog2(N);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] grant_idx;

  assign grant_idx = SELW'(onehot_to_idx(MAX_N'(grant)));

  // Scan the channels starting at ptr, wrapping to 0, and grant the first requester found.
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = RR ? int'(ptr) + off : off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Wrap explicitly at N-1 so that the pointer never takes a value >= N when N is not a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (RR && advance) begin
      ptr <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Arbitrated N-way multiplexer with a registered output stage for shared cpu ports.
// One granted channel per cycle is loaded into the output register when it is empty or draining.
module rr_arb_mux #(
  parameter  int WIDTH = 8,
  parameter  int N     = 3,
  parameter  bit RR    = 1'b1,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);
  import mux_pkg::*;

  logic [N-1:0]    grant;
  logic [SELW-1:0] grant_idx;
  logic            can_load;
  logic            in_xfer;

  // in_ready is derived only from the grant and the register state, so it never depends on out_data.
  assign can_load  = !out_valid || out_ready;
  assign in_ready  = (can_load && !reset) ? grant : '0;
  assign in_xfer   = |(in_valid & in_ready);
  assign grant_idx = SELW'(onehot_to_idx(MAX_N'(grant)));

  rr_arbiter #(
    .N  (N),
    .RR (RR)
  ) u_arbiter (
    .clk     (clk),
    .reset   (reset),
    .req     (in_valid),
    .advance (in_xfer),
    .grant   (grant)
  );

  // A reload takes priority over a drain, so a simultaneous output and input transfer keeps out_valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
